t03_instr_buffer: RTL and testbench
===================================

Name: t03_instr_buffer

Overview:
- Parametrised instruction prefetch buffer between the instruction-memory response path and the decoder.
- Captures fetched words, each with its PC, into a small ring FIFO.
- Presents the head entry to the decoder and holds it stable while the core stalls (out_ready low).
- Discards all contents on a flush (branch/jump redirect); successor to the single-entry freeze/hold register.

Parameters:
- DATA_W, 32, instruction word width.
- PC_W, 32, PC tag width stored per entry.
- DEPTH, 4, entry count; power of two, >= 2.
- NOP_INSTR, 32'h00000013, value driven on out_instr when no valid entry is presented.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard all entries this cycle.
- in_valid  in  1  memory has a fetched word.
- in_ready  out  1  buffer accepts the word this cycle.
- in_data  in  DATA_W  fetched instruction.
- in_pc  in  PC_W  PC of fetched instruction.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decoder consumes head; low = freeze/stall.
- out_instr  out  DATA_W  head instruction, or NOP_INSTR when out_valid=0.
- out_pc  out  PC_W  head PC, or 0 when out_valid=0.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (rst=1 at clk edge): rd_ptr=wr_ptr=0, count=0. Results: out_valid=0, out_instr=NOP_INSTR, out_pc=0, in_ready=1 from the following cycle. Storage contents are not reset.
- Push = in_valid & in_ready. Writes {in_data, in_pc} at wr_ptr; wr_ptr increments mod DEPTH.
- Pop = out_valid & out_ready. rd_ptr increments mod DEPTH.
- in_ready = (count != DEPTH) & ~flush. A full buffer does not accept on a same-cycle pop.
- out_valid = (count != 0). out_instr/out_pc are a combinational read of the head entry at rd_ptr.
- Latency: a word pushed at edge N is visible on out_* after edge N when the buffer was empty.
- Freeze: while out_ready=0 and no flush, out_instr/out_pc/out_valid hold their values across any number of cycles; pushes continue until full.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointer wrap: natural mod-DEPTH rollover; no gap or duplicate across the wrap.
- Flush: at the edge, count=0 and rd_ptr=wr_ptr=0. Flush overrides a same-cycle push (dropped, in_ready=0) and a same-cycle pop (no effect). out_valid=0 from the next cycle.
- rst has priority over flush. rst asserted mid-stream discards everything exactly as flush does and restores reset values.
- count never exceeds DEPTH and never underflows. Pop is impossible when empty by construction.

Optional Feature:
- Macro: T03_INSTR_BYPASS_EN.
- Defined: when count==0 and in_valid=1 and flush=0:
  - out_valid=1, out_instr=in_data, out_pc=in_pc in the same cycle (zero-latency path).
  - If out_ready=1 as well, the word is consumed and not written (count stays 0, pointers unchanged).
  - If out_ready=0, the word is written normally.
- Undefined: no combinational in-to-out path; minimum latency is one cycle as above.

Decomposition:
- Package t03_instr_pkg holds:
  - the NOP_INSTR default constant (RV32I ADDI x0,x0,0);
  - the default DATA_W/PC_W localparams;
  - a packed entry typedef {pc, instr} used by storage and the read mux.
- One natural sub-module: t03_ring_ptr, a parametrised mod-DEPTH pointer and occupancy counter. It takes push, pop and clear and outputs wr_ptr, rd_ptr, count, full and empty. It is instantiated once; the storage array and output mux stay in t03_instr_buffer.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, in_valid=0 -> out_valid=0, out_instr=32'h00000013, out_pc=0, count=0, in_ready=1.
- Fill to full: push 0xA0..0xA3 with PCs 0x100..0x10C, out_ready=0 -> count=4, in_ready=0, out_instr stays 0xA0 and out_pc stays 0x100 for 10 stall cycles; a 5th word 0xA4 is not accepted.
- Drain with wrap: from full, out_ready=1 while pushing 0xB0..0xB5 continuously -> decoder sees 0xA0,0xA1,0xA2,0xA3,0xB0..0xB5 in order with matching PCs, no duplicates across the pointer wrap.
- Flush priority: count=3, assert flush with in_valid=1 (0xC0) and out_ready=1 in the same cycle -> next cycle count=0, out_valid=0, 0xC0 absent; the next push 0xC1 appears as the head.
- Mid-stream reset: count=2, assert rst with in_valid=1 -> next cycle count=0, out_instr=NOP_INSTR; the dropped word never appears.
- Bypass (T03_INSTR_BYPASS_EN): empty, in_valid=1 with 0xD0, out_ready=1 -> out_instr=0xD0 the same cycle, count stays 0. Without the macro -> out_valid=0 that cycle and 0xD0 appears the next cycle.

Source files
------------

// File: rtl/t03_instr_pkg.sv
// Shared constants and entry type for the instruction prefetch buffer.
package t03_instr_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned PC_W_DEF   = 32;

  // RV32I ADDI x0,x0,0 presented to the decoder when nothing is valid
  localparam logic [DATA_W_DEF-1:0] NOP_INSTR_DEF = 32'h0000_0013;

  // One buffered fetch at the default widths
  typedef struct packed {
    logic [PC_W_DEF-1:0]   pc;
    logic [DATA_W_DEF-1:0] instr;
  } instr_entry_t;

endpackage

// File: rtl/t03_ring_ptr.sv
// Mod-DEPTH read/write pointers and occupancy counter for a ring FIFO.
module t03_ring_ptr #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_clear,
  output logic [$clog2(DEPTH)-1:0]     o_wr_ptr,
  output logic [$clog2(DEPTH)-1:0]     o_rd_ptr,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Guard against overflow/underflow even if the caller misbehaves
  always_comb begin
    w_push = i_push & ~o_full;
    w_pop  = i_pop & ~o_empty;
  end

  // Pointer and count update; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_count  = r_count;
  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);

endmodule

// File: rtl/t03_instr_buffer.sv
// Instruction prefetch buffer: ring FIFO of {pc, instr} between fetch and decode.
// Optional zero-latency empty-buffer bypass enabled by `define T03_INSTR_BYPASS_EN.
module t03_instr_buffer
  import t03_instr_pkg::*;
#(
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter int unsigned       PC_W      = PC_W_DEF,
  parameter int unsigned       DEPTH     = 4,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [DATA_W-1:0]          i_in_data,
  input  logic [PC_W-1:0]            i_in_pc,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [DATA_W-1:0]          o_out_instr,
  output logic [PC_W-1:0]            o_out_pc,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  // Entry layout mirrors instr_entry_t but follows the instance widths
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  entry_t           r_mem [DEPTH];
  entry_t           w_head;
  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_bypass;

  t03_ring_ptr #(
    .DEPTH (DEPTH)
  ) u_ring_ptr (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_clear  (i_flush),
    .o_wr_ptr (w_wr_ptr),
    .o_rd_ptr (w_rd_ptr),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  assign w_head  = r_mem[w_rd_ptr];
  assign o_count = w_count;

  // Handshake, bypass decision and head presentation
  always_comb begin
    w_bypass    = 1'b0;
    o_in_ready  = ~w_full & ~i_flush;
    o_out_valid = ~w_empty;
    o_out_instr = NOP_INSTR;
    o_out_pc    = '0;
    w_pop       = ~w_empty & i_out_ready & ~i_flush;
`ifdef T03_INSTR_BYPASS_EN
    w_bypass = w_empty & i_in_valid & ~i_flush;
`endif
    // A bypassed word taken by the decoder this cycle is never stored
    w_push = i_in_valid & o_in_ready & ~(w_bypass & i_out_ready);
    if (!w_empty) begin
      o_out_instr = w_head.instr;
      o_out_pc    = w_head.pc;
    end
`ifdef T03_INSTR_BYPASS_EN
    if (w_bypass) begin
      o_out_valid = 1'b1;
      o_out_instr = i_in_data;
      o_out_pc    = i_in_pc;
    end
`endif
  end

  // Entry storage; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_ptr] <= '{pc: i_in_pc, instr: i_in_data};
    end
  end

endmodule

// File: tb/tb_t03_instr_buffer.sv
// Self-checking bench for t03_instr_buffer (works with or without T03_INSTR_BYPASS_EN).
module tb_t03_instr_buffer;
  import t03_instr_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  instr_entry_t q[$];
  logic [31:0]  seen[$];
  logic [31:0]  exp_seen[$];

  always #5 clk = ~clk;

  t03_instr_buffer #(
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (flush),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .i_in_pc     (in_pc),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_instr (out_instr),
    .o_out_pc    (out_pc),
    .o_count     (count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One clock: drive, check combinational outputs at negedge, update scoreboard at posedge
  task automatic step(input logic r, input logic f, input logic v,
                      input logic [31:0] d, input logic [31:0] p,
                      input logic rdy, output logic acc);
    logic        byp;
    logic        e_valid;
    logic        e_ready;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    rst = r; flush = f; in_valid = v; in_data = d; in_pc = p; out_ready = rdy;
    @(negedge clk);
    byp = 1'b0;
`ifdef T03_INSTR_BYPASS_EN
    byp = (q.size() == 0) && v && !f;
`endif
    e_valid = (q.size() != 0) || byp;
    e_ready = (q.size() != DEPTH) && !f;
    e_instr = byp ? d : ((q.size() != 0) ? q[0].instr : NOP);
    e_pc    = byp ? p : ((q.size() != 0) ? q[0].pc : 32'h0);
    if (!r) begin
      check("out_valid", 64'(out_valid), 64'(e_valid));
      check("out_instr", 64'(out_instr), 64'(e_instr));
      check("out_pc",    64'(out_pc),    64'(e_pc));
      check("in_ready",  64'(in_ready),  64'(e_ready));
      check("count",     64'(count),     64'(q.size()));
      if (!f && e_valid && rdy) seen.push_back(out_instr);
    end
    acc = !r && v && e_ready && !(byp && rdy);
    @(posedge clk);
    if (r || f) begin
      q.delete();
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (acc) q.push_back('{pc: p, instr: d});
    end
    #1;
  endtask

  initial begin
    logic acc;
    int   idx;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_pc = '0; out_ready = 1'b0;

    // Reset then idle
    step(1, 0, 0, 0, 0, 0, acc);
    step(1, 0, 0, 0, 0, 0, acc);
    step(0, 0, 0, 0, 0, 0, acc);
    check("rst_count", 64'(count), 64'(0));
    check("rst_instr", 64'(out_instr), 64'(NOP));

    // Fill to full while the decoder stalls, then offer a fifth word
    for (int i = 0; i < 4; i++)
      step(0, 0, 1, 32'hA0 + 32'(i), 32'h100 + 32'(4*i), 0, acc);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 32'hA4, 32'h110, 0, acc);
      check("stall_a4_rejected", 64'(acc), 64'(0));
    end
    check("full_count", 64'(count), 64'(4));
    check("full_head", 64'(out_instr), 64'(32'hA0));

    // Drain across the pointer wrap while pushing continuously
    idx = 0;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      step(0, 0, 1, 32'hB0 + 32'(idx), 32'h200 + 32'(4*idx), 1, acc);
      if (acc) idx++;
    end
    check("b_words_accepted", 64'(idx), 64'(6));
    for (int c = 0; c < 20 && q.size() != 0; c++)
      step(0, 0, 0, 0, 0, 1, acc);
    check("drain_count", 64'(count), 64'(0));

    // Flush priority over same-cycle push and pop
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 32'hE0 + 32'(i), 32'h300 + 32'(4*i), 0, acc);
    check("pre_flush_count", 64'(count), 64'(3));
    step(0, 1, 1, 32'hC0, 32'h400, 1, acc);
    step(0, 0, 0, 0, 0, 0, acc);
    check("post_flush_valid", 64'(out_valid), 64'(0));
    step(0, 0, 1, 32'hC1, 32'h404, 0, acc);
    step(0, 0, 0, 0, 0, 0, acc);
    check("c1_head", 64'(out_instr), 64'(32'hC1));

    // Mid-stream reset drops everything including the concurrent word
    step(0, 0, 1, 32'hC2, 32'h408, 0, acc);
    check("pre_rst_count", 64'(count), 64'(2));
    step(1, 0, 1, 32'hF0, 32'h500, 1, acc);
    step(0, 0, 0, 0, 0, 0, acc);
    check("post_rst_instr", 64'(out_instr), 64'(NOP));
    step(0, 0, 1, 32'hF1, 32'h504, 0, acc);
    step(0, 0, 0, 0, 0, 1, acc);
    step(0, 0, 0, 0, 0, 1, acc);

    // Empty buffer with a word offered and the decoder ready
    step(0, 0, 1, 32'hD0, 32'h600, 1, acc);
    step(0, 0, 0, 0, 0, 1, acc);
    step(0, 0, 0, 0, 0, 1, acc);
    check("end_count", 64'(count), 64'(0));

    // Everything the decoder consumed, in order
    for (int i = 0; i < 4; i++) exp_seen.push_back(32'hA0 + 32'(i));
    for (int i = 0; i < 6; i++) exp_seen.push_back(32'hB0 + 32'(i));
    exp_seen.push_back(32'hF1);
    exp_seen.push_back(32'hD0);
    check("seen_len", 64'(seen.size()), 64'(exp_seen.size()));
    for (int i = 0; i < exp_seen.size() && i < seen.size(); i++)
      check("seen_order", 64'(seen[i]), 64'(exp_seen[i]));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
